// File: rtl/boutons_debounce_ctrl.sv
// Two-button debouncer with an Avalon-MM register file: debounced state, raw
// synchronized lines, interrupt mask and press-event capture with a level irq.
module boutons_debounce_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic [1:0]  in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_RELEASED,
        S_PRESS_WAIT,
        S_PRESSED,
        S_RELEASE_WAIT
    } btn_state_t;

    // Synchronizer resets to the idle electrical level so the normalised view starts at 0.
    localparam logic [1:0]  SYNC_IDLE = ACTIVE_LOW ? 2'b11 : 2'b00;
    // The entry cycle counts as the first stable sample, so the last count is N-2.
    localparam logic [15:0] CNT_LAST  = 16'(DEBOUNCE_CYCLES - 2);

    logic [1:0]  sync_a_q;
    logic [1:0]  sync_b_q;
    logic [1:0]  btn_norm;
    btn_state_t  state_q [2];
    logic [15:0] cnt_q   [2];
    logic        db_q    [2];
    logic        evt     [2];
    logic [1:0]  db_vec;
    logic [1:0]  press_evt;
    logic [1:0]  irqmask_q, irqmask_d;
    logic [1:0]  edgecap_q, edgecap_d;
    logic [31:0] readdata_q, readdata_d;
    logic        irq_q;
    logic        wr_en;
    logic        unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a_q <= SYNC_IDLE;
            sync_b_q <= SYNC_IDLE;
        end else begin
            sync_a_q <= in_port;
            sync_b_q <= sync_a_q;
        end
    end

    assign btn_norm = ACTIVE_LOW ? ~sync_b_q : sync_b_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            assign evt[gi] = (state_q[gi] == S_PRESS_WAIT) && btn_norm[gi] &&
                             (cnt_q[gi] == CNT_LAST);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_q[gi] <= S_RELEASED;
                    cnt_q[gi]   <= 16'd0;
                    db_q[gi]    <= 1'b0;
                end else begin
                    case (state_q[gi])
                        S_RELEASED: begin
                            if (btn_norm[gi]) begin
                                state_q[gi] <= S_PRESS_WAIT;
                                cnt_q[gi]   <= 16'd0;
                            end
                        end
                        S_PRESS_WAIT: begin
                            if (!btn_norm[gi]) begin
                                state_q[gi] <= S_RELEASED;
                                cnt_q[gi]   <= 16'd0;
                            end else if (cnt_q[gi] == CNT_LAST) begin
                                state_q[gi] <= S_PRESSED;
                                cnt_q[gi]   <= 16'd0;
                                db_q[gi]    <= 1'b1;
                            end else begin
                                cnt_q[gi] <= cnt_q[gi] + 16'd1;
                            end
                        end
                        S_PRESSED: begin
                            if (!btn_norm[gi]) begin
                                state_q[gi] <= S_RELEASE_WAIT;
                                cnt_q[gi]   <= 16'd0;
                            end
                        end
                        S_RELEASE_WAIT: begin
                            if (btn_norm[gi]) begin
                                state_q[gi] <= S_PRESSED;
                                cnt_q[gi]   <= 16'd0;
                            end else if (cnt_q[gi] == CNT_LAST) begin
                                state_q[gi] <= S_RELEASED;
                                cnt_q[gi]   <= 16'd0;
                                db_q[gi]    <= 1'b0;
                            end else begin
                                cnt_q[gi] <= cnt_q[gi] + 16'd1;
                            end
                        end
                        default: begin
                            state_q[gi] <= S_RELEASED;
                            cnt_q[gi]   <= 16'd0;
                            db_q[gi]    <= 1'b0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    assign db_vec    = {db_q[1], db_q[0]};
    assign press_evt = {evt[1], evt[0]};
    assign wr_en     = chipselect & ~write_n;

    always_comb begin
        irqmask_d  = irqmask_q;
        edgecap_d  = edgecap_q;
        readdata_d = 32'd0;
        if (wr_en && address == 2'd2) begin
            irqmask_d = writedata[1:0];
        end
        if (wr_en && address == 2'd3) begin
            edgecap_d = edgecap_q & ~writedata[1:0];
        end
        // A press landing on the same edge as its clear must survive.
        edgecap_d = edgecap_d | press_evt;
        case (address)
            2'd0:    readdata_d[1:0] = db_vec;
            2'd1:    readdata_d[1:0] = sync_b_q;
            2'd2:    readdata_d[1:0] = irqmask_q;
            default: readdata_d[1:0] = edgecap_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q  <= 2'b00;
            edgecap_q  <= 2'b00;
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= |(edgecap_q & irqmask_q);
        end
    end

    assign readdata     = readdata_q;
    assign irq          = irq_q;
    assign unused_wdata = ^writedata[31:2];

endmodule
